// File: rtl/impl_axi_sram_bridge.sv
// AXI4 slave to single-port SRAM bridge.
// Serves one burst at a time (INCR/FIXED) as single-word SRAM accesses; read data
// returns one cycle after the request and is staged in a 2-entry R buffer.
//
// Valid/ready: a transfer happens on a rising edge where both valid and ready are high;
// once valid is raised it stays high with a stable payload until that transfer.
module impl_axi_sram_bridge #(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter int                        AXI_ID_WIDTH   = 16,
    parameter int                        AXI_USER_WIDTH = 10,
    parameter logic [AXI_ADDR_WIDTH-1:0] MEM_BASE       = '0,
    parameter int                        MEM_ADDR_WIDTH = 12
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    // write address channel
    input  logic [AXI_ID_WIDTH-1:0]       aw_id,
    input  logic [AXI_ADDR_WIDTH-1:0]     aw_addr,
    input  logic [7:0]                    aw_len,
    input  logic [2:0]                    aw_size,
    input  logic [1:0]                    aw_burst,
    input  logic                          aw_lock,
    input  logic [3:0]                    aw_cache,
    input  logic [2:0]                    aw_prot,
    input  logic [3:0]                    aw_qos,
    input  logic [3:0]                    aw_region,
    input  logic [AXI_USER_WIDTH-1:0]     aw_user,
    input  logic                          aw_valid,
    output logic                          aw_ready,
    // write data channel
    input  logic [AXI_DATA_WIDTH-1:0]     w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0]   w_strb,
    input  logic                          w_last,
    input  logic [AXI_USER_WIDTH-1:0]     w_user,
    input  logic                          w_valid,
    output logic                          w_ready,
    // write response channel
    output logic [AXI_ID_WIDTH-1:0]       b_id,
    output logic [1:0]                    b_resp,
    output logic [AXI_USER_WIDTH-1:0]     b_user,
    output logic                          b_valid,
    input  logic                          b_ready,
    // read address channel
    input  logic [AXI_ID_WIDTH-1:0]       ar_id,
    input  logic [AXI_ADDR_WIDTH-1:0]     ar_addr,
    input  logic [7:0]                    ar_len,
    input  logic [2:0]                    ar_size,
    input  logic [1:0]                    ar_burst,
    input  logic                          ar_lock,
    input  logic [3:0]                    ar_cache,
    input  logic [2:0]                    ar_prot,
    input  logic [3:0]                    ar_qos,
    input  logic [3:0]                    ar_region,
    input  logic [AXI_USER_WIDTH-1:0]     ar_user,
    input  logic                          ar_valid,
    output logic                          ar_ready,
    // read data channel
    output logic [AXI_ID_WIDTH-1:0]       r_id,
    output logic [AXI_DATA_WIDTH-1:0]     r_data,
    output logic [1:0]                    r_resp,
    output logic                          r_last,
    output logic [AXI_USER_WIDTH-1:0]     r_user,
    output logic                          r_valid,
    input  logic                          r_ready,
    // SRAM port
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [AXI_DATA_WIDTH-1:0]     mem_wdata_o,
    output logic [AXI_DATA_WIDTH/8-1:0]   mem_be_o,
    input  logic [AXI_DATA_WIDTH-1:0]     mem_rdata_i,
    // FSM state for observation
    output logic [1:0]                    dbg_state
);

    localparam int ADDR_LSB = $clog2(AXI_DATA_WIDTH / 8);
    localparam logic [AXI_ADDR_WIDTH-1:0] MEM_LIMIT =
        AXI_ADDR_WIDTH'(longint'(1) << (MEM_ADDR_WIDTH + ADDR_LSB));
    localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_INC = AXI_ADDR_WIDTH'(1 << ADDR_LSB);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WRESP, S_READ} state_t;

    state_t                      state;
    logic                        prio_write;   // 1: write wins the next AW/AR collision
    logic [AXI_ID_WIDTH-1:0]     id_q;
    logic [AXI_ADDR_WIDTH-1:0]   off_q;        // byte offset of the current beat inside the window
    logic [7:0]                  len_q;
    logic                        fixed_q;
    logic                        bad_q;        // WRAP or reserved burst type
    logic                        dec_q;        // some write beat fell outside the window
    logic [7:0]                  beat_q;       // W beats taken / R beats delivered
    logic [8:0]                  issued_q;     // read beats issued
    logic                        pend_q;       // a read beat was issued last cycle
    logic                        pend_mem_q;   // ... and it really went to the SRAM
    logic [1:0]                  pend_resp_q;

    logic [AXI_DATA_WIDTH-1:0]   fifo_data [2];
    logic [1:0]                  fifo_resp [2];
    logic                        rd_ptr;
    logic                        wr_ptr;
    logic [1:0]                  fifo_cnt;

    logic                        in_range;
    logic                        grant_aw;
    logic                        grant_ar;
    logic                        w_fire;
    logic                        r_fire;
    logic                        rd_issue;
    logic [2:0]                  occ;
    logic [1:0]                  rd_resp;
    logic                        unused_inputs;

    assign unused_inputs = ^{aw_size, aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_user,
                             ar_size, ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user,
                             w_last, w_user};

    assign in_range = off_q < MEM_LIMIT;
    assign grant_aw = rst_ni && (state == S_IDLE) && aw_valid && (!ar_valid || prio_write);
    assign grant_ar = rst_ni && (state == S_IDLE) && ar_valid && (!aw_valid || !prio_write);
    assign aw_ready = grant_aw;
    assign ar_ready = grant_ar;

    assign w_ready = (state == S_WRITE);
    assign w_fire  = w_ready && w_valid;

    assign r_valid = (fifo_cnt != 2'd0);
    assign r_fire  = r_valid && r_ready;
    assign r_data  = fifo_data[rd_ptr];
    assign r_resp  = fifo_resp[rd_ptr];
    assign r_last  = (beat_q == len_q);
    assign r_id    = id_q;
    assign r_user  = '0;

    // Slots committed after this cycle's pop; a pop frees room for a same-cycle issue.
    assign occ      = {1'b0, fifo_cnt} + {2'b00, pend_q} - {2'b00, r_fire};
    assign rd_issue = (state == S_READ) && (occ < 3'd2) && (issued_q <= {1'b0, len_q});
    assign rd_resp  = bad_q ? RESP_SLVERR : (in_range ? RESP_OKAY : RESP_DECERR);

    assign b_valid = (state == S_WRESP);
    assign b_id    = id_q;
    assign b_resp  = bad_q ? RESP_SLVERR : (dec_q ? RESP_DECERR : RESP_OKAY);
    assign b_user  = '0;

    assign mem_req_o   = (w_fire || rd_issue) && !bad_q && in_range;
    assign mem_we_o    = w_fire;
    assign mem_addr_o  = off_q[ADDR_LSB +: MEM_ADDR_WIDTH];
    assign mem_wdata_o = w_data;
    assign mem_be_o    = w_strb;
    assign dbg_state   = state;

    // Transaction FSM with arbitration, burst address walk and R buffer bookkeeping.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            prio_write  <= 1'b1;
            pend_q      <= 1'b0;
            pend_mem_q  <= 1'b0;
            pend_resp_q <= RESP_OKAY;
            fifo_cnt    <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            beat_q      <= 8'd0;
            issued_q    <= 9'd0;
            dec_q       <= 1'b0;
        end else begin
            pend_q      <= rd_issue;
            pend_mem_q  <= rd_issue && !bad_q && in_range;
            pend_resp_q <= rd_resp;
            if (pend_q) wr_ptr <= ~wr_ptr;
            if (r_fire) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, pend_q} - {1'b0, r_fire};
            case (state)
                S_IDLE: begin
                    if (grant_aw) begin
                        id_q    <= aw_id;
                        off_q   <= aw_addr - MEM_BASE;
                        len_q   <= aw_len;
                        fixed_q <= (aw_burst == 2'b00);
                        bad_q   <= aw_burst[1];
                        dec_q   <= 1'b0;
                        beat_q  <= 8'd0;
                        if (ar_valid) prio_write <= 1'b0;
                        state   <= S_WRITE;
                    end else if (grant_ar) begin
                        id_q     <= ar_id;
                        off_q    <= ar_addr - MEM_BASE;
                        len_q    <= ar_len;
                        fixed_q  <= (ar_burst == 2'b00);
                        bad_q    <= ar_burst[1];
                        beat_q   <= 8'd0;
                        issued_q <= 9'd0;
                        if (aw_valid) prio_write <= 1'b1;
                        state    <= S_READ;
                    end
                end
                S_WRITE: begin
                    if (w_fire) begin
                        if (!in_range) dec_q <= 1'b1;
                        if (!fixed_q) off_q <= off_q + BEAT_INC;
                        beat_q <= beat_q + 8'd1;
                        if (beat_q == len_q) state <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (b_ready) state <= S_IDLE;
                end
                S_READ: begin
                    if (rd_issue) begin
                        issued_q <= issued_q + 9'd1;
                        if (!fixed_q) off_q <= off_q + BEAT_INC;
                    end
                    if (r_fire) begin
                        beat_q <= beat_q + 8'd1;
                        if (beat_q == len_q) state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // R buffer storage: SRAM data (or zero for suppressed beats) lands one cycle after issue.
    always_ff @(posedge clk_i) begin
        if (pend_q) begin
            fifo_data[wr_ptr] <= pend_mem_q ? mem_rdata_i : '0;
            fifo_resp[wr_ptr] <= pend_resp_q;
        end
    end

endmodule

// File: tb/tb_impl_axi_sram_bridge.sv
// Bench for impl_axi_sram_bridge: directed scenarios plus random bursts, checked by a
// scoreboard against a word-array model of the SRAM window.
module tb_impl_axi_sram_bridge;

    localparam int IW        = 16;
    localparam int UW        = 10;
    localparam int MAW       = 12;
    localparam int MEM_WORDS = 1 << MAW;
    localparam logic [31:0] MEM_BASE = 32'h0000_0000;
    localparam logic [1:0]  B_FIXED  = 2'b00;
    localparam logic [1:0]  B_INCR   = 2'b01;
    localparam logic [1:0]  B_WRAP   = 2'b10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [IW-1:0] aw_id, ar_id, b_id, r_id;
    logic [31:0]   aw_addr, ar_addr, w_data, r_data;
    logic [7:0]    aw_len, ar_len;
    logic [1:0]    aw_burst, ar_burst, b_resp, r_resp;
    logic [3:0]    w_strb;
    logic          aw_valid, aw_ready, ar_valid, ar_ready, w_valid, w_ready, w_last;
    logic          b_valid, b_ready, r_valid, r_ready, r_last;
    logic [UW-1:0] b_user, r_user;
    logic          mem_req_o, mem_we_o;
    logic [MAW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o, mem_rdata_i;
    logic [3:0]    mem_be_o;
    logic [1:0]    dbg_state;

    impl_axi_sram_bridge dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(3'd2), .aw_burst(aw_burst),
        .aw_lock(1'b0), .aw_cache(4'd0), .aw_prot(3'd0), .aw_qos(4'd0), .aw_region(4'd0),
        .aw_user('0), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_user('0),
        .w_valid(w_valid), .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_user(b_user), .b_valid(b_valid), .b_ready(b_ready),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(3'd2), .ar_burst(ar_burst),
        .ar_lock(1'b0), .ar_cache(4'd0), .ar_prot(3'd0), .ar_qos(4'd0), .ar_region(4'd0),
        .ar_user('0), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_user(r_user),
        .r_valid(r_valid), .r_ready(r_ready),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i),
        .dbg_state(dbg_state)
    );

    // ---------------- SRAM with 1-cycle read latency ----------------
    bit [31:0] sram [MEM_WORDS];
    bit [31:0] sram_rdata;
    assign mem_rdata_i = sram_rdata;
    always @(posedge clk) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                sram_rdata <= sram[mem_addr_o];
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    bit [31:0]   ref_mem [MEM_WORDS];
    logic [17:0] exp_b_q[$];   // {id, resp}
    logic [50:0] exp_r_q[$];   // {id, data, resp, last}
    logic [48:0] exp_m_q[$];   // {we, word, wdata, be}
    logic [31:0] wr_data [256];
    logic [3:0]  wr_strb [256];
    int total = 0;
    int bad   = 0;
    int r_mode = 0;            // 0: always ready, 1: random, 2: 1,0,0 pattern, 3: never
    int b_mode = 0;            // 0: always ready, 1: random
    int rr_k = 0;
    bit chk_out = 0;
    int out_cnt = 0;
    int max_out = 0;
    time aw_t, ar_t;
    time r_times[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] beat_off(input logic [31:0] addr, input logic [1:0] burst,
                                             input int i);
        return addr - MEM_BASE + ((burst == B_INCR) ? 32'(i * 4) : 32'd0);
    endfunction

    task automatic model_write(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                               input logic [1:0] burst);
        logic [31:0] off;
        logic        dec;
        logic [MAW-1:0] wd;
        dec = 1'b0;
        for (int i = 0; i <= len; i++) begin
            off = beat_off(addr, burst, i);
            wd  = off[MAW+1:2];
            if (off >= 32'(MEM_WORDS * 4)) dec = 1'b1;
            else if (!burst[1]) begin
                for (int b = 0; b < 4; b++)
                    if (wr_strb[i][b]) ref_mem[wd][8*b +: 8] = wr_data[i][8*b +: 8];
                exp_m_q.push_back({1'b1, wd, wr_data[i], wr_strb[i]});
            end
        end
        exp_b_q.push_back({id, burst[1] ? 2'b10 : (dec ? 2'b11 : 2'b00)});
    endtask

    task automatic model_read(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                              input logic [1:0] burst);
        logic [31:0] off;
        logic [31:0] d;
        logic [1:0]  rs;
        logic [MAW-1:0] wd;
        for (int i = 0; i <= len; i++) begin
            off = beat_off(addr, burst, i);
            wd  = off[MAW+1:2];
            d   = 32'd0;
            if (burst[1]) rs = 2'b10;
            else if (off >= 32'(MEM_WORDS * 4)) rs = 2'b11;
            else begin
                rs = 2'b00;
                d  = ref_mem[wd];
                exp_m_q.push_back({1'b0, wd, 32'd0, 4'd0});
            end
            exp_r_q.push_back({id, d, rs, (i == len)});
        end
    endtask

    // Monitor: pops the expected queues whenever the DUT completes a transfer.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                if (aw_valid && aw_ready) aw_t = $time;
                if (ar_valid && ar_ready) ar_t = $time;
                if (b_valid && b_ready) begin
                    if (exp_b_q.size() == 0) check("b_unexpected", 64'(b_id), 64'hx);
                    else begin
                        e = 64'(exp_b_q.pop_front());
                        check("b_beat", 64'({b_id, b_resp}), e);
                    end
                end
                if (r_valid && r_ready) begin
                    r_times.push_back($time);
                    if (exp_r_q.size() == 0) check("r_unexpected", 64'(r_data), 64'hx);
                    else begin
                        e = 64'(exp_r_q.pop_front());
                        check("r_beat", 64'({r_id, r_data, r_resp, r_last}), e);
                    end
                end
                if (mem_req_o) begin
                    if (exp_m_q.size() == 0) check("mem_unexpected", 64'(mem_addr_o), 64'hx);
                    else begin
                        e = 64'(exp_m_q.pop_front());
                        check("mem_access", 64'({mem_we_o, mem_addr_o,
                              mem_we_o ? mem_wdata_o : 32'd0, mem_we_o ? mem_be_o : 4'd0}), e);
                    end
                end
                if (chk_out) begin
                    out_cnt += int'(mem_req_o && !mem_we_o);
                    out_cnt -= int'(r_valid && r_ready);
                    if (out_cnt > max_out) max_out = out_cnt;
                end
            end
        end
    end

    // Ready drivers for the response channels.
    initial begin
        r_ready = 1'b0;
        b_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (r_mode)
                0:       r_ready = 1'b1;
                1:       r_ready = 1'($urandom_range(0, 1));
                2:       r_ready = (rr_k % 3 == 0);
                default: r_ready = 1'b0;
            endcase
            b_ready = (b_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            rr_k++;
        end
    end

    // ---------------- driver tasks (start and end at posedge+1) ----------------
    task automatic drive_aw(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst);
        int n = 0;
        logic got = 1'b0;
        aw_id = id; aw_addr = addr; aw_len = 8'(len); aw_burst = burst; aw_valid = 1'b1;
        while (!got && n < 500) begin
            @(negedge clk); got = aw_ready; @(posedge clk); #1; n++;
        end
        aw_valid = 1'b0;
        if (!got) check("aw_timeout", 64'd0, 64'd1);
    endtask

    task automatic drive_ar(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst);
        int n = 0;
        logic got = 1'b0;
        ar_id = id; ar_addr = addr; ar_len = 8'(len); ar_burst = burst; ar_valid = 1'b1;
        while (!got && n < 500) begin
            @(negedge clk); got = ar_ready; @(posedge clk); #1; n++;
        end
        ar_valid = 1'b0;
        if (!got) check("ar_timeout", 64'd0, 64'd1);
    endtask

    task automatic drive_w(input int len, input bit gaps);
        int n;
        logic got;
        for (int i = 0; i <= len; i++) begin
            w_valid = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            w_data = wr_data[i]; w_strb = wr_strb[i]; w_last = (i == len); w_valid = 1'b1;
            n = 0; got = 1'b0;
            while (!got && n < 500) begin
                @(negedge clk); got = w_ready; @(posedge clk); #1; n++;
            end
            if (!got) begin
                check("w_timeout", 64'd0, 64'd1);
                break;
            end
        end
        w_valid = 1'b0;
    endtask

    task automatic fill_wdata(input int len);
        for (int i = 0; i <= len; i++) begin
            wr_data[i] = $urandom;
            wr_strb[i] = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_b_q.size() != 0 || exp_r_q.size() != 0 || exp_m_q.size() != 0) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 3000) check({name, "_drain_timeout"}, 64'd0, 64'd1);
        @(posedge clk); #1;
        check({name, "_idle_state"}, 64'(dbg_state), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        aw_valid = 0; ar_valid = 0; w_valid = 0; w_last = 0;
        aw_id = 0; aw_addr = 0; aw_len = 0; aw_burst = 0;
        ar_id = 0; ar_addr = 0; ar_len = 0; ar_burst = 0;
        w_data = 0; w_strb = 0;
        rst_ni = 1'b0;
        // valids raised during reset must not be accepted
        aw_valid = 1'b1; ar_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({aw_ready, ar_ready, w_ready, b_valid, r_valid, mem_req_o}), 64'd0);
        check("reset_state", 64'(dbg_state), 64'd0);
        @(posedge clk); #1;
        aw_valid = 1'b0; ar_valid = 1'b0;
        rst_ni = 1'b1;
        @(negedge clk);
        check("post_reset_outputs", 64'({aw_ready, ar_ready, w_ready, b_valid, r_valid, mem_req_o}), 64'd0);
        @(posedge clk); #1;

        // 1: INCR write of 4 full words at word 4
        for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hd000_0000 + 32'(i); wr_strb[i] = 4'hf; end
        model_write(16'd5, MEM_BASE + 32'h10, 3, B_INCR);
        fork
            drive_aw(16'd5, MEM_BASE + 32'h10, 3, B_INCR);
            drive_w(3, 1'b0);
        join
        wait_idle("t1");

        // 2: read it back at full rate
        r_mode = 0;
        r_times.delete();
        model_read(16'd9, MEM_BASE + 32'h10, 3, B_INCR);
        drive_ar(16'd9, MEM_BASE + 32'h10, 3, B_INCR);
        wait_idle("t2");
        check("t2_beat_count", 64'(r_times.size()), 64'd4);
        if (r_times.size() == 4) check("t2_back_to_back", 64'(r_times[3] - r_times[0]), 64'd30);

        // 3: len=7 with a throttled R channel
        r_mode = 2; out_cnt = 0; max_out = 0; chk_out = 1;
        model_read(16'd3, MEM_BASE + 32'h8, 7, B_INCR);
        drive_ar(16'd3, MEM_BASE + 32'h8, 7, B_INCR);
        wait_idle("t3");
        chk_out = 0;
        total++;
        if (max_out > 2) begin
            bad++;
            $display("FAIL t3_outstanding actual=%0d limit=2", max_out);
        end
        r_mode = 0;

        // 4: AW/AR collisions; write wins first, read wins the next one
        fill_wdata(1);
        model_write(16'd21, MEM_BASE + 32'd400, 1, B_INCR);
        model_read(16'd22, MEM_BASE + 32'd800, 1, B_INCR);
        fork
            drive_aw(16'd21, MEM_BASE + 32'd400, 1, B_INCR);
            drive_w(1, 1'b0);
            drive_ar(16'd22, MEM_BASE + 32'd800, 1, B_INCR);
        join
        wait_idle("t4a");
        check("t4a_write_first", 64'(aw_t < ar_t), 64'd1);
        fill_wdata(1);
        model_read(16'd24, MEM_BASE + 32'd400, 1, B_INCR);
        model_write(16'd23, MEM_BASE + 32'd808, 1, B_FIXED);
        fork
            drive_aw(16'd23, MEM_BASE + 32'd808, 1, B_FIXED);
            drive_w(1, 1'b0);
            drive_ar(16'd24, MEM_BASE + 32'd400, 1, B_INCR);
        join
        wait_idle("t4b");
        check("t4b_read_first", 64'(ar_t < aw_t), 64'd1);

        // 5: write crossing the top of the window, then a WRAP read
        fill_wdata(1);
        model_write(16'd7, MEM_BASE + 32'((MEM_WORDS - 1) * 4), 1, B_INCR);
        fork
            drive_aw(16'd7, MEM_BASE + 32'((MEM_WORDS - 1) * 4), 1, B_INCR);
            drive_w(1, 1'b0);
        join
        wait_idle("t5a");
        model_read(16'd8, MEM_BASE + 32'h20, 2, B_WRAP);
        drive_ar(16'd8, MEM_BASE + 32'h20, 2, B_WRAP);
        wait_idle("t5b");

        // 6: reset in the middle of a stalled read burst
        r_mode = 3;
        model_read(16'd11, MEM_BASE + 32'd1200, 7, B_INCR);
        drive_ar(16'd11, MEM_BASE + 32'd1200, 7, B_INCR);
        repeat (5) begin @(posedge clk); #1; end
        rst_ni = 1'b0;
        exp_r_q.delete(); exp_m_q.delete(); exp_b_q.delete();
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(negedge clk);
        check("t6_after_reset", 64'({r_valid, b_valid, w_ready, aw_ready, ar_ready, mem_req_o}), 64'd0);
        check("t6_state", 64'(dbg_state), 64'd0);
        @(posedge clk); #1;
        r_mode = 0;
        model_read(16'd12, MEM_BASE + 32'h10, 3, B_INCR);
        drive_ar(16'd12, MEM_BASE + 32'h10, 3, B_INCR);
        wait_idle("t6_new_read");

        // random bursts, including out-of-range and bad burst types
        r_mode = 1; b_mode = 1;
        for (int t = 0; t < 24; t++) begin
            int len, sel;
            logic [1:0]  burst;
            logic [31:0] addr;
            logic [IW-1:0] id;
            len  = $urandom_range(0, 7);
            sel  = $urandom_range(0, 9);
            burst = (sel < 3) ? B_FIXED : ((sel < 9) ? B_INCR : 2'($urandom_range(2, 3)));
            addr = MEM_BASE + 32'($urandom_range(MEM_WORDS - 10, MEM_WORDS + 2) * 4);
            if ($urandom_range(0, 1) == 1) addr = MEM_BASE + 32'($urandom_range(0, 63) * 4);
            id   = IW'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                fill_wdata(len);
                model_write(id, addr, len, burst);
                fork
                    drive_aw(id, addr, len, burst);
                    drive_w(len, 1'b1);
                join
            end else begin
                model_read(id, addr, len, burst);
                drive_ar(id, addr, len, burst);
            end
            wait_idle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit.
    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "time limit reached");
    end

endmodule
